hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL use parameter TIMEOUT, default 255: consecutive stalled memory-wait cycles before a fatal error.
REQ-002 The block SHALL use parameter CNT_W, default 32: width of the stall-cycle counter.
REQ-003 The block SHALL have the following ports:
- clk_i  in  1  sole clock; all state updates on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- id_sel_rs1_i  in  5  rs1 of instruction in ID.
- id_sel_rs2_i  in  5  rs2 of instruction in ID.
- id_uses_rs1_i  in  1  ID instruction reads rs1.
- id_uses_rs2_i  in  1  ID instruction reads rs2.
- ex_mem_read_i  in  1  EX instruction is a load.
- ex_sel_rd_i  in  5  rd of EX instruction.
- branch_taken_i  in  1  EX resolved a taken branch or jump.
- dmem_req_i  in  1  MEM stage has a data-memory access outstanding.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- stall_pc_o  out  1  hold PC.
- stall_if_id_o  out  1  hold IF/ID register.
- stall_id_ex_o  out  1  hold ID/EX register.
- stall_ex_mem_o  out  1  hold EX/MEM register.
- flush_if_id_o  out  1  load bubble into IF/ID.
- flush_id_ex_o  out  1  load bubble into ID/EX.
- flush_mem_wb_o  out  1  load bubble into MEM/WB.
- mem_timeout_o  out  1  sticky fatal error flag.
- stall_cycles_o  out  CNT_W  saturating count of cycles with stall_pc_o=1.

Function
REQ-004 The block SHALL implement FSM states RUN, MEM_WAIT and ERROR, with state and counters registered and control outputs combinational from state and inputs.
REQ-005 The block SHALL define memwait as dmem_req_i=1 and dmem_ack_i=0.
REQ-006 In RUN or MEM_WAIT with memwait, the block SHALL assert all four stall_* outputs and flush_mem_wb_o, assert no other flush, and move to or stay in MEM_WAIT.
REQ-007 In MEM_WAIT with dmem_ack_i=1, or with dmem_req_i=0, the block SHALL release all memory stalls in that same cycle and return to RUN the next cycle.
REQ-008 The block SHALL keep a wait counter that clears in RUN and increments each MEM_WAIT cycle with memwait.
REQ-009 When the wait counter reaches TIMEOUT while memwait holds, the block SHALL go to ERROR.
REQ-010 In ERROR, the block SHALL hold all stall_* outputs at 1, hold all flush_* outputs at 0 and hold mem_timeout_o at 1, ignoring all other inputs until reset.
REQ-011 The block SHALL define load-use as ex_mem_read_i=1, ex_sel_rd_i≠0, and (id_uses_rs1_i=1 and id_sel_rs1_i=ex_sel_rd_i, or id_uses_rs2_i=1 and id_sel_rs2_i=ex_sel_rd_i).
REQ-012 In RUN without memwait or branch_taken_i, on load-use the block SHALL assert stall_pc_o, stall_if_id_o and flush_id_ex_o for exactly that cycle (one bubble).
REQ-013 The block SHALL not detect a load-use hazard on x0, even when ex_mem_read_i=1.
REQ-014 In RUN without memwait, on branch_taken_i=1 the block SHALL assert flush_if_id_o and flush_id_ex_o with stall_pc_o=0 so the PC loads the target, overriding any simultaneous load-use.
REQ-015 On simultaneous memwait and branch_taken_i, memwait SHALL win and the branch SHALL be ignored while frozen; because EX is held, branch_taken_i re-presents and is acted on in the release cycle.
REQ-016 On simultaneous memwait and load-use, memwait SHALL win and load-use SHALL be re-evaluated in the release cycle.
REQ-017 Priority SHALL be ERROR > memwait > branch > load-use > none; with none active, all control outputs SHALL be 0.
REQ-018 stall_cycles_o SHALL increment by 1 in every cycle with stall_pc_o=1 and saturate at all-ones, never wrapping.

Reset
REQ-019 While rst_ni=0 at a clock edge, the block SHALL set state to RUN and clear the wait counter, stall_cycles_o and mem_timeout_o.
REQ-020 During reset cycles, all control outputs SHALL be 0 regardless of inputs.
REQ-021 A reset asserted mid MEM_WAIT or in ERROR SHALL return the block to RUN with zeroed counters on the next edge.
REQ-022 ERROR SHALL be left only through reset.

Verification
REQ-023 Bench SHALL cover load-use: ex_mem_read_i=1, ex_sel_rd_i=5, id_sel_rs2_i=5, id_uses_rs2_i=1 -> one cycle of stall_pc_o=stall_if_id_o=flush_id_ex_o=1, then all 0, and stall_cycles_o=1.
REQ-024 Bench SHALL cover x0 load: same as REQ-023 with ex_sel_rd_i=0 and id_sel_rs1_i=0 -> all control outputs 0.
REQ-025 Bench SHALL cover branch plus load-use in the same cycle -> flush_if_id_o=flush_id_ex_o=1 and stall_pc_o=0.
REQ-026 Bench SHALL cover a memory wait: dmem_req_i=1, ack after 3 cycles -> 3 cycles of all stalls plus flush_mem_wb_o, released in the ack cycle, and stall_cycles_o=3.
REQ-027 Bench SHALL cover timeout: TIMEOUT=4 and dmem_req_i=1 with no ack -> mem_timeout_o=1 and stalls stuck at 1; rst_ni=0 for one edge -> all outputs 0 and state RUN.
REQ-028 Bench SHALL cover counter saturation: CNT_W=4 with 20 stall cycles -> stall_cycles_o=15.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and data-memory wait
// freezing, with a wait-timeout fatal error and a saturating count of PC-stall cycles.
module hazard_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_sel_rs1_i,
  input  logic [4:0]       id_sel_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_sel_rd_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             stall_pc_o,
  output logic             stall_if_id_o,
  output logic             stall_id_ex_o,
  output logic             stall_ex_mem_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             flush_mem_wb_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               timeout_q, timeout_d;

  logic memwait;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign memwait  = dmem_req_i & ~dmem_ack_i;
  assign rs1_hit  = id_uses_rs1_i & (id_sel_rs1_i == ex_sel_rd_i);
  assign rs2_hit  = id_uses_rs2_i & (id_sel_rs2_i == ex_sel_rd_i);
  // x0 is hardwired to zero, so a load targeting it can never create a dependency
  assign load_use = ex_mem_read_i & (ex_sel_rd_i != 5'd0) & (rs1_hit | rs2_hit);

  // Control outputs: priority ERROR > memwait > branch > load-use, all quiet in reset
  always_comb begin
    stall_pc_o     = 1'b0;
    stall_if_id_o  = 1'b0;
    stall_id_ex_o  = 1'b0;
    stall_ex_mem_o = 1'b0;
    flush_if_id_o  = 1'b0;
    flush_id_ex_o  = 1'b0;
    flush_mem_wb_o = 1'b0;
    if (rst_ni) begin
      if (state_q == ERROR) begin
        stall_pc_o     = 1'b1;
        stall_if_id_o  = 1'b1;
        stall_id_ex_o  = 1'b1;
        stall_ex_mem_o = 1'b1;
      end else if (memwait) begin
        stall_pc_o     = 1'b1;
        stall_if_id_o  = 1'b1;
        stall_id_ex_o  = 1'b1;
        stall_ex_mem_o = 1'b1;
        flush_mem_wb_o = 1'b1;
      end else if (branch_taken_i) begin
        flush_if_id_o  = 1'b1;
        flush_id_ex_o  = 1'b1;
      end else if (load_use) begin
        stall_pc_o     = 1'b1;
        stall_if_id_o  = 1'b1;
        flush_id_ex_o  = 1'b1;
      end
    end
  end

  assign mem_timeout_o  = rst_ni & timeout_q;
  assign stall_cycles_o = stall_cnt_q;

  // Next-state: wait timeout tracking and stall-cycle accounting
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (memwait) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (memwait) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_d == TIMEOUT_CNT) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall_pc_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule
